// File: rtl/cpu_ctrl.sv
// cpu_ctrl: MEM-stage control unit owning the control registers (CRs); commits
// WRCR/EXRT/exceptions, arbitrates level-sensitive IRQs, drives stall/flush and NewPC.
// Optional macro CPU_CYCLE_COUNTER_EN adds a free-running 32-bit CYCLE register at CR 7.
// Flush and NewPC are combinational in the event cycle; CR updates land on the edge.
module cpu_ctrl #(
  parameter int          IRQ_W          = 8,
  parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             IFBusy,
  input  logic             MEMBusy,
  input  logic             LDHazard,
  input  logic [IRQ_W-1:0] IRQ,
  input  logic             MEMEn,
  input  logic [29:0]      MEMPC,
  input  logic             MEMBrFlag,
  input  logic [1:0]       MEMCtrlOp,
  input  logic [4:0]       MEMDstAddr,
  input  logic [2:0]       MEMExpCode,
  input  logic [31:0]      MEMOut,
  input  logic [4:0]       CRegRdAddr,
  output logic [31:0]      CRegRdData,
  output logic             ExeMode,
  output logic             IFStall,
  output logic             IDStall,
  output logic             EXStall,
  output logic             MEMStall,
  output logic             IFFlush,
  output logic             IDFlush,
  output logic             EXFlush,
  output logic             MEMFlush,
  output logic [29:0]      NewPC
);

  // Control operation encodings
  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  // Cause code reported for an external interrupt
  localparam logic [2:0] EXP_EXT_INT = 3'd1;

  // CR word addresses
  localparam logic [4:0] CR_STATUS     = 5'd0;
  localparam logic [4:0] CR_PRE_STATUS = 5'd1;
  localparam logic [4:0] CR_EXP_VECTOR = 5'd2;
  localparam logic [4:0] CR_CAUSE      = 5'd3;
  localparam logic [4:0] CR_INT_MASK   = 5'd4;
  localparam logic [4:0] CR_IRQ        = 5'd5;
  localparam logic [4:0] CR_EPC        = 5'd6;
`ifdef CPU_CYCLE_COUNTER_EN
  localparam logic [4:0] CR_CYCLE      = 5'd7;
`endif

  // STATUS layout: bit 1 = IntEn, bit 0 = Mode (0 kernel, 1 user)
  localparam int ST_INTEN = 1;
  localparam int ST_MODE  = 0;

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [1:0]       status_q,     status_d;
  logic [1:0]       pre_status_q, pre_status_d;
  logic [29:0]      exp_vector_q, exp_vector_d;
  logic             cause_dly_q,  cause_dly_d;
  logic [2:0]       cause_code_q, cause_code_d;
  logic [IRQ_W-1:0] int_mask_q,   int_mask_d;
  logic [29:0]      epc_q,        epc_d;
  logic [29:0]      new_pc_q,     new_pc_d;
`ifdef CPU_CYCLE_COUNTER_EN
  logic [31:0]      cycle_q,      cycle_d;
`endif

  // ---------------------------------------------------------------------------
  // Event detection and arbitration
  // ---------------------------------------------------------------------------
  logic        stall;
  logic        mem_live;
  logic        irq_pending;
  logic        evt_exc;
  logic        evt_int;
  logic        evt_exrt;
  logic        evt_wrcr;
  logic        evt_any;
  logic        evt_trap;
  logic [29:0] evt_target;
  logic        flush_all;

  // Stall fabric and the single-winner event selection
  always_comb begin
    stall       = IFBusy | MEMBusy;
    mem_live    = MEMEn & ~stall;
    irq_pending = status_q[ST_INTEN] & (|(IRQ & ~int_mask_q));

    evt_exc  = mem_live & (MEMExpCode != 3'd0);
    evt_int  = mem_live & ~evt_exc & irq_pending;
    evt_exrt = mem_live & ~evt_exc & ~evt_int & (MEMCtrlOp == OP_EXRT);
    evt_wrcr = mem_live & ~evt_exc & ~evt_int & ~evt_exrt & (MEMCtrlOp == OP_WRCR);
    evt_trap = evt_exc | evt_int;
    evt_any  = evt_trap | evt_exrt | evt_wrcr;

    evt_target = new_pc_q;
    if (evt_trap) begin
      evt_target = exp_vector_q;
    end else if (evt_exrt) begin
      evt_target = epc_q;
    end else if (evt_wrcr) begin
      evt_target = MEMPC + 30'd1;
    end
  end

  // Pipeline control outputs; reset forces flushes and NewPC low
  always_comb begin
    flush_all = reset_ & evt_any;

    IFStall  = stall | LDHazard;
    IDStall  = stall;
    EXStall  = stall;
    MEMStall = stall;

    IFFlush  = flush_all;
    IDFlush  = flush_all | (reset_ & LDHazard & ~stall);
    EXFlush  = flush_all;
    MEMFlush = flush_all;

    NewPC    = reset_ ? evt_target : 30'd0;
    ExeMode  = status_q[ST_MODE];
  end

  // ---------------------------------------------------------------------------
  // Next-state for CRs
  // ---------------------------------------------------------------------------
  // Trap entry, EXRT return and WRCR writes; only the arbitration winner acts
  always_comb begin
    status_d     = status_q;
    pre_status_d = pre_status_q;
    exp_vector_d = exp_vector_q;
    cause_dly_d  = cause_dly_q;
    cause_code_d = cause_code_q;
    int_mask_d   = int_mask_q;
    epc_d        = epc_q;
    new_pc_d     = evt_any ? evt_target : new_pc_q;

    if (evt_trap) begin
      pre_status_d = status_q;
      status_d     = 2'b00;
      cause_code_d = evt_exc ? MEMExpCode : EXP_EXT_INT;
      // A faulting delay-slot instruction restarts at its branch
      if (MEMBrFlag) begin
        epc_d       = MEMPC - 30'd1;
        cause_dly_d = 1'b1;
      end else begin
        epc_d       = MEMPC;
        cause_dly_d = 1'b0;
      end
    end else if (evt_exrt) begin
      status_d = pre_status_q;
    end else if (evt_wrcr) begin
      case (MEMDstAddr)
        CR_STATUS:     status_d     = MEMOut[1:0];
        CR_PRE_STATUS: pre_status_d = MEMOut[1:0];
        CR_EXP_VECTOR: exp_vector_d = MEMOut[31:2];
        CR_CAUSE: begin
          cause_dly_d  = MEMOut[3];
          cause_code_d = MEMOut[2:0];
        end
        CR_INT_MASK:   int_mask_d   = MEMOut[IRQ_W-1:0];
        CR_EPC:        epc_d        = MEMOut[31:2];
        default: ;
      endcase
    end
  end

`ifdef CPU_CYCLE_COUNTER_EN
  // Free-running counter; a WRCR load wins over the increment
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (evt_wrcr && (MEMDstAddr == CR_CYCLE)) begin
      cycle_d = MEMOut;
    end
  end
`endif

  // CR storage with asynchronous reset
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      status_q     <= 2'b00;
      pre_status_q <= 2'b00;
      exp_vector_q <= EXP_VECTOR_RST;
      cause_dly_q  <= 1'b0;
      cause_code_q <= 3'd0;
      int_mask_q   <= '1;
      epc_q        <= 30'd0;
      new_pc_q     <= 30'd0;
    end else begin
      status_q     <= status_d;
      pre_status_q <= pre_status_d;
      exp_vector_q <= exp_vector_d;
      cause_dly_q  <= cause_dly_d;
      cause_code_q <= cause_code_d;
      int_mask_q   <= int_mask_d;
      epc_q        <= epc_d;
      new_pc_q     <= new_pc_d;
    end
  end

`ifdef CPU_CYCLE_COUNTER_EN
  // Cycle counter storage
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  logic [31:0] mask_ext;
  logic [31:0] irq_ext;

  // Combinational CR read; unused bits and unmapped addresses return zero
  always_comb begin
    mask_ext              = '0;
    mask_ext[IRQ_W-1:0]   = int_mask_q;
    irq_ext               = '0;
    irq_ext[IRQ_W-1:0]    = IRQ;

    CRegRdData = 32'd0;
    case (CRegRdAddr)
      CR_STATUS:     CRegRdData = {30'd0, status_q};
      CR_PRE_STATUS: CRegRdData = {30'd0, pre_status_q};
      CR_EXP_VECTOR: CRegRdData = {exp_vector_q, 2'b00};
      CR_CAUSE:      CRegRdData = {28'd0, cause_dly_q, cause_code_q};
      CR_INT_MASK:   CRegRdData = mask_ext;
      CR_IRQ:        CRegRdData = irq_ext;
      CR_EPC:        CRegRdData = {epc_q, 2'b00};
`ifdef CPU_CYCLE_COUNTER_EN
      CR_CYCLE:      CRegRdData = cycle_q;
`endif
      default:       CRegRdData = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: reset, traps, interrupts, EXRT, WRCR, stalls,
// load-use hazard and asynchronous reset during a pending event.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        IFBusy, MEMBusy, LDHazard;
  logic [7:0]  IRQ;
  logic        MEMEn;
  logic [29:0] MEMPC;
  logic        MEMBrFlag;
  logic [1:0]  MEMCtrlOp;
  logic [4:0]  MEMDstAddr;
  logic [2:0]  MEMExpCode;
  logic [31:0] MEMOut;
  logic [4:0]  CRegRdAddr;
  logic [31:0] CRegRdData;
  logic        ExeMode;
  logic        IFStall, IDStall, EXStall, MEMStall;
  logic        IFFlush, IDFlush, EXFlush, MEMFlush;
  logic [29:0] NewPC;

  int tests  = 0;
  int failed = 0;

  wire [3:0] stalls  = {IFStall, IDStall, EXStall, MEMStall};
  wire [3:0] flushes = {IFFlush, IDFlush, EXFlush, MEMFlush};

  cpu_ctrl #(.IRQ_W(8), .EXP_VECTOR_RST(30'h0)) dut (
    .clk(clk), .reset_(reset_),
    .IFBusy(IFBusy), .MEMBusy(MEMBusy), .LDHazard(LDHazard), .IRQ(IRQ),
    .MEMEn(MEMEn), .MEMPC(MEMPC), .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp),
    .MEMDstAddr(MEMDstAddr), .MEMExpCode(MEMExpCode), .MEMOut(MEMOut),
    .CRegRdAddr(CRegRdAddr), .CRegRdData(CRegRdData), .ExeMode(ExeMode),
    .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MEMStall(MEMStall),
    .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush),
    .NewPC(NewPC)
  );

  always #5 clk = ~clk;

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    CRegRdAddr = a;
    #1;
  endtask

  task automatic clear_mem();
    MEMEn = 1'b0; MEMCtrlOp = 2'd0; MEMExpCode = 3'd0; MEMBrFlag = 1'b0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d, input logic [29:0] pc);
    sync();
    MEMEn = 1'b1; MEMCtrlOp = 2'd1; MEMDstAddr = a; MEMOut = d; MEMPC = pc;
    sync();
    clear_mem();
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    IFBusy = 1'b1; MEMBusy = 1'b0; LDHazard = 1'b0; IRQ = 8'h00;
    clear_mem(); MEMPC = 30'h0; MEMDstAddr = 5'd0; MEMOut = 32'h0; CRegRdAddr = 5'd0;
    #12;
    tests++; if (stalls !== 4'hF) begin failed++; $display("FAIL reset_stall_comb got=%h exp=F", stalls); end
    tests++; if (flushes !== 4'h0 || NewPC !== 30'h0) begin failed++; $display("FAIL reset_outputs flush=%h newpc=%h exp 0/0", flushes, NewPC); end
    IFBusy = 1'b0;
    sync();
    reset_ = 1'b1;
    rd(5'd0);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL reset_status got=%h exp=0", CRegRdData); end
    rd(5'd4);
    tests++; if (CRegRdData !== 32'hFF) begin failed++; $display("FAIL reset_int_mask got=%h exp=ff", CRegRdData); end
    tests++; if (ExeMode !== 1'b0 || flushes !== 4'h0) begin failed++; $display("FAIL reset_mode_flush mode=%b flush=%h exp 0/0", ExeMode, flushes); end
  endtask

  task automatic test_exception();
    wrcr(5'd2, 32'h100, 30'h10);
    sync();
    MEMEn = 1'b1; MEMExpCode = 3'd5; MEMPC = 30'h100; MEMBrFlag = 1'b0;
    #1;
    tests++; if (flushes !== 4'hF || NewPC !== 30'h40) begin failed++; $display("FAIL exc_flush flush=%h newpc=%h exp F/40", flushes, NewPC); end
    sync();
    clear_mem();
    rd(5'd6);
    tests++; if (CRegRdData !== 32'h400) begin failed++; $display("FAIL exc_epc got=%h exp=400", CRegRdData); end
    rd(5'd3);
    tests++; if (CRegRdData !== 32'h5) begin failed++; $display("FAIL exc_cause got=%h exp=5", CRegRdData); end
    tests++; if (NewPC !== 30'h40 || flushes !== 4'h0) begin failed++; $display("FAIL exc_newpc_hold newpc=%h flush=%h exp 40/0", NewPC, flushes); end
  endtask

  task automatic test_interrupt_exrt();
    wrcr(5'd0, 32'h3, 30'h30);
    wrcr(5'd4, 32'hFE, 30'h31);
    sync();
    IRQ = 8'h01; MEMEn = 1'b1; MEMCtrlOp = 2'd0; MEMPC = 30'h20;
    #1;
    tests++; if (flushes !== 4'hF || NewPC !== 30'h40) begin failed++; $display("FAIL int_flush flush=%h newpc=%h exp F/40", flushes, NewPC); end
    sync();
    clear_mem(); IRQ = 8'h00;
    rd(5'd0);
    tests++; if (CRegRdData !== 32'h0 || ExeMode !== 1'b0) begin failed++; $display("FAIL int_status got=%h mode=%b exp 0/0", CRegRdData, ExeMode); end
    rd(5'd1);
    tests++; if (CRegRdData !== 32'h3) begin failed++; $display("FAIL int_pre_status got=%h exp=3", CRegRdData); end
    rd(5'd3);
    tests++; if (CRegRdData !== 32'h1) begin failed++; $display("FAIL int_cause got=%h exp=1", CRegRdData); end
    rd(5'd6);
    tests++; if (CRegRdData !== 32'h80) begin failed++; $display("FAIL int_epc got=%h exp=80", CRegRdData); end
    sync();
    MEMEn = 1'b1; MEMCtrlOp = 2'd2; MEMPC = 30'h99;
    #1;
    tests++; if (flushes !== 4'hF || NewPC !== 30'h20) begin failed++; $display("FAIL exrt_newpc flush=%h newpc=%h exp F/20", flushes, NewPC); end
    sync();
    clear_mem();
    rd(5'd0);
    tests++; if (CRegRdData !== 32'h3 || ExeMode !== 1'b1) begin failed++; $display("FAIL exrt_restore got=%h mode=%b exp 3/1", CRegRdData, ExeMode); end
  endtask

  task automatic test_priority();
    // Exception, pending interrupt and EXRT together: exception wins
    sync();
    IRQ = 8'h01; MEMEn = 1'b1; MEMExpCode = 3'd3; MEMCtrlOp = 2'd2; MEMPC = 30'h55;
    #1;
    tests++; if (NewPC !== 30'h40) begin failed++; $display("FAIL prio_exc_newpc got=%h exp=40", NewPC); end
    sync();
    clear_mem(); IRQ = 8'h00;
    rd(5'd3);
    tests++; if (CRegRdData !== 32'h3) begin failed++; $display("FAIL prio_exc_cause got=%h exp=3", CRegRdData); end
    rd(5'd6);
    tests++; if (CRegRdData !== 32'h154) begin failed++; $display("FAIL prio_exc_epc got=%h exp=154", CRegRdData); end
    // Interrupt beats EXRT
    wrcr(5'd0, 32'h3, 30'h0);
    sync();
    IRQ = 8'h01; MEMEn = 1'b1; MEMCtrlOp = 2'd2; MEMPC = 30'h60;
    #1;
    tests++; if (NewPC !== 30'h40) begin failed++; $display("FAIL prio_int_newpc got=%h exp=40", NewPC); end
    sync();
    clear_mem(); IRQ = 8'h00;
    rd(5'd3);
    tests++; if (CRegRdData !== 32'h1) begin failed++; $display("FAIL prio_int_cause got=%h exp=1", CRegRdData); end
  endtask

  task automatic test_delay_slot();
    sync();
    MEMEn = 1'b1; MEMExpCode = 3'd5; MEMBrFlag = 1'b1; MEMPC = 30'h0;
    sync();
    clear_mem();
    rd(5'd6);
    tests++; if (CRegRdData !== 32'hFFFFFFFC) begin failed++; $display("FAIL dly_epc_wrap got=%h exp=fffffffc", CRegRdData); end
    rd(5'd3);
    tests++; if (CRegRdData !== 32'hD) begin failed++; $display("FAIL dly_cause got=%h exp=d", CRegRdData); end
    sync();
    MEMEn = 1'b1; MEMExpCode = 3'd2; MEMBrFlag = 1'b1; MEMPC = 30'h10;
    sync();
    clear_mem();
    rd(5'd6);
    tests++; if (CRegRdData !== 32'h3C) begin failed++; $display("FAIL dly_epc got=%h exp=3c", CRegRdData); end
  endtask

  task automatic test_stall();
    sync();
    MEMBusy = 1'b1; MEMEn = 1'b1; MEMCtrlOp = 2'd1; MEMDstAddr = 5'd0; MEMOut = 32'h1; MEMPC = 30'h77;
    #1;
    tests++; if (stalls !== 4'hF || flushes !== 4'h0) begin failed++; $display("FAIL stall_out stall=%h flush=%h exp F/0", stalls, flushes); end
    tests++; if (NewPC !== 30'h40) begin failed++; $display("FAIL stall_newpc_hold got=%h exp=40", NewPC); end
    sync();
    tests++; if (ExeMode !== 1'b0 || flushes !== 4'h0) begin failed++; $display("FAIL stall_no_update mode=%b flush=%h exp 0/0", ExeMode, flushes); end
    MEMBusy = 1'b0;
    #1;
    tests++; if (flushes !== 4'hF || NewPC !== 30'h78) begin failed++; $display("FAIL stall_release flush=%h newpc=%h exp F/78", flushes, NewPC); end
    sync();
    clear_mem();
    tests++; if (ExeMode !== 1'b1) begin failed++; $display("FAIL stall_mode got=%b exp=1", ExeMode); end
    IFBusy = 1'b1; MEMEn = 1'b1; MEMExpCode = 3'd5;
    #1;
    tests++; if (stalls !== 4'hF || flushes !== 4'h0) begin failed++; $display("FAIL ifbusy stall=%h flush=%h exp F/0", stalls, flushes); end
    IFBusy = 1'b0; clear_mem();
  endtask

  task automatic test_wrcr_misc();
    sync();
    MEMEn = 1'b1; MEMCtrlOp = 2'd1; MEMDstAddr = 5'd5; MEMOut = 32'hFFFF; MEMPC = 30'h3FFFFFFF;
    #1;
    tests++; if (NewPC !== 30'h0 || flushes !== 4'hF) begin failed++; $display("FAIL wrcr_pc_wrap newpc=%h flush=%h exp 0/F", NewPC, flushes); end
    sync();
    clear_mem(); IRQ = 8'hA5;
    rd(5'd5);
    tests++; if (CRegRdData !== 32'hA5) begin failed++; $display("FAIL irq_read got=%h exp=a5", CRegRdData); end
    IRQ = 8'h00;
    wrcr(5'd9, 32'hFFFFFFFF, 30'h1);
    rd(5'd9);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL unmapped got=%h exp=0", CRegRdData); end
    wrcr(5'd3, 32'hFFFFFFFF, 30'h2);
    rd(5'd3);
    tests++; if (CRegRdData !== 32'hF) begin failed++; $display("FAIL cause_bits got=%h exp=f", CRegRdData); end
    wrcr(5'd1, 32'hFFFFFFFF, 30'h3);
    rd(5'd1);
    tests++; if (CRegRdData !== 32'h3) begin failed++; $display("FAIL pre_status_bits got=%h exp=3", CRegRdData); end
    wrcr(5'd2, 32'hFFFFFFFF, 30'h4);
    rd(5'd2);
    tests++; if (CRegRdData !== 32'hFFFFFFFC) begin failed++; $display("FAIL exp_vector_bits got=%h exp=fffffffc", CRegRdData); end
`ifdef CPU_CYCLE_COUNTER_EN
    wrcr(5'd7, 32'hFFFFFFFE, 30'h5);
    rd(5'd7);
    tests++; if (CRegRdData !== 32'hFFFFFFFE) begin failed++; $display("FAIL cycle_load got=%h exp=fffffffe", CRegRdData); end
    rd(5'd7);
    tests++; if (CRegRdData !== 32'hFFFFFFFF) begin failed++; $display("FAIL cycle_inc got=%h exp=ffffffff", CRegRdData); end
    rd(5'd7);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL cycle_wrap got=%h exp=0", CRegRdData); end
`else
    wrcr(5'd7, 32'h12345678, 30'h5);
    rd(5'd7);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL cycle_absent got=%h exp=0", CRegRdData); end
`endif
  endtask

  task automatic test_irq_masked();
    wrcr(5'd0, 32'h2, 30'h6);
    sync();
    IRQ = 8'h02; MEMEn = 1'b1; MEMCtrlOp = 2'd0;
    #1;
    tests++; if (flushes !== 4'h0) begin failed++; $display("FAIL irq_masked flush=%h exp=0", flushes); end
    MEMEn = 1'b0; IRQ = 8'h01;
    #1;
    tests++; if (flushes !== 4'h0) begin failed++; $display("FAIL irq_no_memen flush=%h exp=0", flushes); end
    MEMEn = 1'b1;
    #1;
    tests++; if (flushes !== 4'hF) begin failed++; $display("FAIL irq_unmasked flush=%h exp=F", flushes); end
    MEMEn = 1'b0; IRQ = 8'h00;
  endtask

  task automatic test_ldhazard();
    sync();
    LDHazard = 1'b1;
    #1;
    tests++; if (stalls !== 4'b1000 || flushes !== 4'b0100) begin failed++; $display("FAIL ldhazard stall=%b flush=%b exp 1000/0100", stalls, flushes); end
    MEMBusy = 1'b1;
    #1;
    tests++; if (stalls !== 4'hF || flushes !== 4'h0) begin failed++; $display("FAIL ldhazard_busy stall=%h flush=%h exp F/0", stalls, flushes); end
    LDHazard = 1'b0; MEMBusy = 1'b0;
  endtask

  task automatic test_reset_mid_event();
    wrcr(5'd0, 32'h1, 30'h7);
    sync();
    MEMEn = 1'b1; MEMExpCode = 3'd6; MEMPC = 30'h123;
    #1;
    reset_ = 1'b0;
    #1;
    tests++; if (flushes !== 4'h0 || NewPC !== 30'h0 || ExeMode !== 1'b0) begin failed++; $display("FAIL reset_mid flush=%h newpc=%h mode=%b exp 0/0/0", flushes, NewPC, ExeMode); end
    sync();
    clear_mem();
    reset_ = 1'b1;
    rd(5'd6);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL reset_mid_epc got=%h exp=0", CRegRdData); end
    rd(5'd3);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL reset_mid_cause got=%h exp=0", CRegRdData); end
    rd(5'd2);
    tests++; if (CRegRdData !== 32'h0) begin failed++; $display("FAIL reset_mid_vector got=%h exp=0", CRegRdData); end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_interrupt_exrt();
    test_priority();
    test_delay_slot();
    test_stall();
    test_wrcr_misc();
    test_irq_masked();
    test_ldhazard();
    test_reset_mid_event();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
